// File: rtl/fibonacci_index.sv
//------------------------------------------------------------------------------
// Module   : fibonacci_index
// Brief    : Iterative inverse Fibonacci search: largest n with F(n) <= din,
//            plus an exact-hit flag, behind a start/done handshake.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fibonacci_index #(
  parameter int WIDTH     = 16,
  parameter int IDX_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     din,
  input  logic                 start,
  output logic [IDX_WIDTH-1:0] dout,
  output logic                 found,
  output logic                 done,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_target;
  logic [WIDTH:0]       r_a;
  logic [WIDTH:0]       r_b;
  logic [IDX_WIDTH-1:0] r_k;

  // One extra bit keeps F(k+1) representable when it first exceeds the target.
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_target_ext;
  logic                 w_hit;
  logic                 w_past;

  assign w_sum        = r_a + r_b;
  assign w_target_ext = {1'b0, r_target};
  assign w_hit        = (r_a == w_target_ext);
  assign w_past       = (r_b >  w_target_ext);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_target <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_k      <= '0;
      dout     <= '0;
      found    <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_target <= din;
            r_a      <= '0;
            r_b      <= {{WIDTH{1'b0}}, 1'b1};
            r_k      <= '0;
            done     <= 1'b0;
            found    <= 1'b0;
            busy     <= 1'b1;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          // Exact hit is tested first so the duplicate F(1)=F(2)=1 resolves to n=1.
          if (w_hit) begin
            dout    <= r_k;
            found   <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end else if (w_past) begin
            dout    <= r_k;
            found   <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_a <= r_b;
            r_b <= w_sum;
            r_k <= r_k + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fibonacci_index.sv
//------------------------------------------------------------------------------
// Module   : tb_fibonacci_index
// Brief    : Directed, table-driven self-checking bench for fibonacci_index.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fibonacci_index;

  logic        clk;
  logic        reset;
  logic [15:0] din;
  logic        start;
  logic [5:0]  dout;
  logic        found;
  logic        done;
  logic        busy;

  int checks;
  int failures;

  fibonacci_index #(
    .WIDTH     (16),
    .IDX_WIDTH (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .start (start),
    .dout  (dout),
    .found (found),
    .done  (done),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] v;
    int          exp_dout;
    bit          exp_found;
  } vec_t;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Caller must be positioned just after a rising edge.
  task automatic run_search(input logic [15:0] v, input int exp_dout,
                            input bit exp_found, input string tag);
    int cyc;
    start = 1'b1;
    din   = v;
    @(posedge clk); #1;
    start = 1'b0;
    din   = ~v;
    check({tag, " busy_after_start"}, int'(busy), 1);
    check({tag, " done_after_start"}, int'(done), 0);
    cyc = 0;
    while (!done && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, cyc, exp_dout + 1);
    check({tag, " dout"}, int'(dout), exp_dout);
    check({tag, " found"}, int'(found), int'(exp_found));
    check({tag, " busy_at_done"}, int'(busy), 0);
  endtask

  vec_t vecs[11];

  initial begin
    int fa, fb, ft;
    logic [5:0] held;

    checks   = 0;
    failures = 0;

    vecs[0]  = '{16'd55,    10, 1'b1};
    vecs[1]  = '{16'd5,     5,  1'b1};
    vecs[2]  = '{16'd4,     4,  1'b0};
    vecs[3]  = '{16'd0,     0,  1'b1};
    vecs[4]  = '{16'd1,     1,  1'b1};
    vecs[5]  = '{16'd65535, 24, 1'b0};
    vecs[6]  = '{16'd46368, 24, 1'b1};
    vecs[7]  = '{16'd2,     3,  1'b1};
    vecs[8]  = '{16'd100,   11, 1'b0};
    vecs[9]  = '{16'd144,   12, 1'b1};
    vecs[10] = '{16'd7,     5,  1'b0};

    reset = 1'b1;
    start = 1'b0;
    din   = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset dout",  int'(dout),  0);
    check("reset found", int'(found), 0);
    check("reset done",  int'(done),  0);
    check("reset busy",  int'(busy),  0);

    // Back-to-back vectors also exercise restarting directly from DONE.
    for (int i = 0; i < 11; i++)
      run_search(vecs[i].v, vecs[i].exp_dout, vecs[i].exp_found,
                 $sformatf("vec%0d", i));

    held = dout;
    repeat (3) @(posedge clk);
    #1;
    check("done_hold dout", int'(dout), int'(held));
    check("done_hold done", int'(done), 1);

    // Start ignored mid-search, then reset abandons it.
    start = 1'b1;
    din   = 16'd55;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    din   = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    check("ignored_start busy", int'(busy), 1);
    check("ignored_start done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort dout",  int'(dout),  0);
    check("abort found", int'(found), 0);
    check("abort done",  int'(done),  0);
    check("abort busy",  int'(busy),  0);
    @(posedge clk); #1;
    check("abort idle busy", int'(busy), 0);
    check("abort idle done", int'(done), 0);
    run_search(16'd3, 4, 1'b1, "after_abort");

    // Round trip; F(2)=1 duplicates F(1), so the smaller index is expected there.
    fa = 0;
    fb = 1;
    for (int n = 0; n <= 24; n++) begin
      run_search(fa[15:0], (n == 2) ? 1 : n, 1'b1, $sformatf("rt%0d", n));
      ft = fa + fb;
      fa = fb;
      fb = ft;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
